count_arbiter: RTL and testbench

COUNT_ARBITER -- requirements
Module: count_arbiter

---
 rtl/count_arbiter.sv | 95 +++++++++
 tb/tb_count_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter that owns one shared down-counter.
// A grant loads the requester's length and the counter runs down to a one-cycle done pulse.
module count_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;

  logic             pick;
  logic [WIDTH-1:0] pick_len;
  logic             owner_req;

  // On a tie, the requester that did not win last time gets the counter.
  assign pick      = (req0 && req1) ? ~last_q : req1;
  assign pick_len  = pick ? len1 : len0;
  assign owner_req = owner_q ? req1 : req0;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 || req1) begin
          owner_d = pick;
          last_d  = pick;
          cnt_d   = pick_len;
          state_d = (pick_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // A dropped request wins over expiry: aborted intervals never pulse done.
        if (!owner_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= WIDTH'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign gnt0  = (state_q == RUN)  && !owner_q;
  assign gnt1  = (state_q == RUN)  &&  owner_q;
  assign done0 = (state_q == DONE) && !owner_q;
  assign done1 = (state_q == DONE) &&  owner_q;
  assign busy  = (state_q != IDLE);
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Table-driven bench for count_arbiter: each record drives one cycle and queues
// the outputs expected after the following rising edge.
module tb_count_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         res;
  logic         req0, req1;
  logic [W-1:0] len0, len1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] cnt;

  count_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .res(res),
    .req0(req0), .len0(len0), .req1(req1), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // op: 0 = drive one cycle and check after the edge
  //     1 = synchronous-window reset (checks outputs during reset)
  //     2 = asynchronous reset pulse between edges (checks immediate clear)
  typedef struct {
    int           op;
    logic         r0;
    logic [W-1:0] l0;
    logic         r1;
    logic [W-1:0] l1;
    logic [12:0]  exp;   // {gnt0,gnt1,done0,done1,busy,cnt}
  } vec_t;

  vec_t        tbl[$];
  logic [12:0] sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic vec_t v(input int op, input logic r0, input logic [W-1:0] l0,
                             input logic r1, input logic [W-1:0] l1,
                             input logic g0, input logic g1, input logic d0,
                             input logic d1, input logic b, input logic [W-1:0] c);
    vec_t t;
    t.op = op; t.r0 = r0; t.l0 = l0; t.r1 = r1; t.l1 = l1;
    t.exp = {g0, g1, d0, d1, b, c};
    return t;
  endfunction

  task automatic check(input string nm, input int idx, input logic [12:0] e);
    logic [12:0] a;
    a = {gnt0, gnt1, done0, done1, busy, cnt};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s step %0d: got g0=%b g1=%b d0=%b d1=%b busy=%b cnt=%0d, want g0=%b g1=%b d0=%b d1=%b busy=%b cnt=%0d",
               nm, idx, a[12], a[11], a[10], a[9], a[8], a[7:0],
               e[12], e[11], e[10], e[9], e[8], e[7:0]);
    end
  endtask

  initial begin
    res = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    #2;

    // Single request, len0=5
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 5, 0, 0, 1, 0, 0, 0, 1, 5));
    tbl.push_back(v(0, 1, 5, 0, 0, 1, 0, 0, 0, 1, 4));
    tbl.push_back(v(0, 1, 5, 0, 0, 1, 0, 0, 0, 1, 3));
    tbl.push_back(v(0, 1, 5, 0, 0, 1, 0, 0, 0, 1, 2));
    tbl.push_back(v(0, 1, 5, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 5, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));

    // Tie and rotation, len0=3, len1=2
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, 1, 2, 1, 0, 0, 0, 1, 3));
    tbl.push_back(v(0, 1, 3, 1, 2, 1, 0, 0, 0, 1, 2));
    tbl.push_back(v(0, 1, 3, 1, 2, 1, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 3, 1, 2, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, 1, 2, 0, 1, 0, 0, 1, 2));
    tbl.push_back(v(0, 1, 3, 1, 2, 0, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 3, 1, 2, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, 1, 2, 1, 0, 0, 0, 1, 3));
    tbl.push_back(v(0, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0));

    // Zero length on requester 1
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Abort after 4 gnt0 cycles, pending req1 then served
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 10, 1, 3, 1, 0, 0, 0, 1, 10));
    tbl.push_back(v(0, 1, 10, 1, 3, 1, 0, 0, 0, 1, 9));
    tbl.push_back(v(0, 1, 10, 1, 3, 1, 0, 0, 0, 1, 8));
    tbl.push_back(v(0, 1, 10, 1, 3, 1, 0, 0, 0, 1, 7));
    tbl.push_back(v(0, 0, 10, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 10, 1, 3, 0, 1, 0, 0, 1, 3));
    tbl.push_back(v(0, 0, 10, 0, 3, 0, 0, 0, 0, 0, 0));

    // Reset mid-run with gnt1 and cnt=7; tie afterwards goes to requester 0
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 9, 0, 1, 0, 0, 1, 9));
    tbl.push_back(v(0, 0, 0, 1, 9, 0, 1, 0, 0, 1, 8));
    tbl.push_back(v(0, 0, 0, 1, 9, 0, 1, 0, 0, 1, 7));
    tbl.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 2, 1, 2, 1, 0, 0, 0, 1, 2));
    tbl.push_back(v(0, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0));

    // Max length 255: counts all the way down without wrapping
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 255; i++)
      tbl.push_back(v(0, 1, 255, 0, 0, 1, 0, 0, 0, 1, W'(255 - i)));
    tbl.push_back(v(0, 1, 255, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 255, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 255, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        1: begin
          res = 1'b1; req0 = 1'b0; req1 = 1'b0;
          #1 check("reset_async", i, tbl[i].exp);
          @(posedge clk);
          #1 check("reset_held", i, tbl[i].exp);
          res = 1'b0;
        end
        2: begin
          res = 1'b1; req0 = 1'b0; req1 = 1'b0;
          #1 check("reset_midrun", i, tbl[i].exp);
          #1 res = 1'b0;
        end
        default: begin
          req0 = tbl[i].r0; len0 = tbl[i].l0;
          req1 = tbl[i].r1; len1 = tbl[i].l1;
          sb.push_back(tbl[i].exp);
          @(posedge clk);
          #1 check("cycle", i, sb.pop_front());
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Mutual-exclusion invariants checked on every falling edge once out of reset.
  always @(negedge clk) begin
    if (!res) begin
      n_chk++;
      if ((gnt0 && gnt1) || (done0 && done1) || ((done0 || done1) && (gnt0 || gnt1))) begin
        n_fail++;
        $display("FAIL exclusivity: got g0=%b g1=%b d0=%b d1=%b, want at most one active",
                 gnt0, gnt1, done0, done1);
      end
    end
  end

endmodule
